// File: rtl/load_store_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_pkg
// Description : Shared FSM state encoding and default widths for the
//               load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package load_store_unit_pkg;

    localparam int unsigned LSU_ADDR_W    = 16;
    localparam int unsigned LSU_DATA_W    = 16;
    localparam int unsigned LSU_MEM_WORDS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } lsu_state_t;

endpackage
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store unit in front of a word-addressed
//               data memory with a fixed read wait.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned ADDR_W    = LSU_ADDR_W,
    parameter int unsigned DATA_W    = LSU_DATA_W,
    parameter int unsigned MEM_WORDS = LSU_MEM_WORDS,
    parameter int unsigned RD_WAIT   = 1
)(
    input  logic              clk,
    input  logic              clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_load,
    input  logic [DATA_W-1:0] mem_output_data,
    output logic              busy
);

    // Counter preload; with no wait cycles the WAIT state is skipped entirely.
    localparam logic [3:0]        c_WAIT_INIT = (RD_WAIT == 0) ? 4'd0 : 4'(RD_WAIT - 1);
    localparam logic              c_NO_WAIT   = (RD_WAIT == 0);
    // Range limit widened so the compare never truncates either operand.
    localparam logic [ADDR_W+31:0] c_MEM_LIMIT = (ADDR_W + 32)'(MEM_WORDS);

    lsu_state_t        r_state;
    lsu_state_t        w_next_state;
    logic              r_write;
    logic [3:0]        r_wait_cnt;
    logic [ADDR_W-1:0] r_mem_address;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_resp_rdata;
    logic              r_resp_err;
    logic              w_req_ready;
    logic              w_accept;
    logic              w_addr_err;
    logic              w_sample;
    logic              w_mem_load;

    assign w_req_ready = (r_state == ST_IDLE) && clr;
    assign w_accept    = req_valid && w_req_ready;
    assign w_addr_err  = ({32'd0, req_addr} >= c_MEM_LIMIT);

    // State register.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode, read-data sample point and store strobe.
    always_comb begin
        w_next_state = r_state;
        w_sample     = 1'b0;
        w_mem_load   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = w_addr_err ? ST_RESP : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (r_write) begin
                    w_mem_load   = 1'b1;
                    w_next_state = ST_RESP;
                end else if (c_NO_WAIT) begin
                    w_sample     = 1'b1;
                    w_next_state = ST_RESP;
                end else begin
                    w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_wait_cnt == 4'd0) begin
                    w_sample     = 1'b1;
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Request capture, wait counter and response data registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_write       <= 1'b0;
            r_wait_cnt    <= 4'd0;
            r_mem_address <= '0;
            r_mem_wdata   <= '0;
            r_resp_rdata  <= '0;
            r_resp_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write      <= req_write;
                r_resp_rdata <= '0;
                r_resp_err   <= w_addr_err;
                // Out-of-range requests never touch the memory-side registers.
                if (!w_addr_err) begin
                    r_mem_address <= req_addr;
                    r_mem_wdata   <= req_wdata;
                end
            end
            if (r_state == ST_ISSUE) begin
                r_wait_cnt <= c_WAIT_INIT;
            end else if ((r_state == ST_WAIT) && (r_wait_cnt != 4'd0)) begin
                r_wait_cnt <= r_wait_cnt - 4'd1;
            end
            if (w_sample) begin
                r_resp_rdata <= mem_output_data;
            end
        end
    end

    assign req_ready      = w_req_ready;
    assign resp_valid     = (r_state == ST_RESP);
    assign resp_rdata     = r_resp_rdata;
    assign resp_err       = r_resp_err;
    assign mem_address    = r_mem_address;
    assign mem_write_data = r_mem_wdata;
    assign mem_load       = w_mem_load;
    assign busy           = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Self-checking bench; one unit with RD_WAIT=1 and one with
//               RD_WAIT=0, each with its own data memory, against a
//               transaction-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        req_write = 1'b0;
    logic [15:0] req_addr  = '0;
    logic [15:0] req_wdata = '0;
    logic        rv1 = 1'b0, rv0 = 1'b0;
    logic        rr1 = 1'b0, rr0 = 1'b0;

    logic        req_ready1, resp_valid1, resp_err1, mem_load1, busy1;
    logic [15:0] resp_rdata1, mem_address1, mem_write_data1, mem_output_data1;
    logic        req_ready0, resp_valid0, resp_err0, mem_load0, busy0;
    logic [15:0] resp_rdata0, mem_address0, mem_write_data0, mem_output_data0;

    // Data memories seen by each unit (environment, not the reference model).
    logic [15:0] env_mem1 [4] = '{16'd1, 16'd22, 16'd5, 16'd0};
    logic [15:0] env_mem0 [4] = '{16'd1, 16'd22, 16'd5, 16'd0};

    // Reference model: memory contents and last valid address per unit.
    logic [15:0] model_mem [2][4];
    logic [15:0] last_addr [2];

    int checks   = 0;
    int failures = 0;
    logic sel0 = 1'b0;   // 1 selects the RD_WAIT=0 unit

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(16), .DATA_W(16), .MEM_WORDS(4), .RD_WAIT(1)) dut (
        .clk(clk), .clr(clr), .req_valid(rv1), .req_ready(req_ready1),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid1), .resp_ready(rr1), .resp_rdata(resp_rdata1),
        .resp_err(resp_err1), .mem_address(mem_address1),
        .mem_write_data(mem_write_data1), .mem_load(mem_load1),
        .mem_output_data(mem_output_data1), .busy(busy1)
    );

    load_store_unit #(.ADDR_W(16), .DATA_W(16), .MEM_WORDS(4), .RD_WAIT(0)) dut0 (
        .clk(clk), .clr(clr), .req_valid(rv0), .req_ready(req_ready0),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid0), .resp_ready(rr0), .resp_rdata(resp_rdata0),
        .resp_err(resp_err0), .mem_address(mem_address0),
        .mem_write_data(mem_write_data0), .mem_load(mem_load0),
        .mem_output_data(mem_output_data0), .busy(busy0)
    );

    assign mem_output_data1 = (mem_address1 < 16'd4) ? env_mem1[mem_address1[1:0]] : 16'hDEAD;
    assign mem_output_data0 = (mem_address0 < 16'd4) ? env_mem0[mem_address0[1:0]] : 16'hDEAD;

    always @(posedge clk) begin
        if (mem_load1 && (mem_address1 < 16'd4)) env_mem1[mem_address1[1:0]] <= mem_write_data1;
        if (mem_load0 && (mem_address0 < 16'd4)) env_mem0[mem_address0[1:0]] <= mem_write_data0;
    end

    // Observation muxes for the unit under test in the current phase.
    wire        o_req_ready  = sel0 ? req_ready0  : req_ready1;
    wire        o_resp_valid = sel0 ? resp_valid0 : resp_valid1;
    wire        o_resp_err   = sel0 ? resp_err0   : resp_err1;
    wire        o_mem_load   = sel0 ? mem_load0   : mem_load1;
    wire        o_busy       = sel0 ? busy0       : busy1;
    wire [15:0] o_resp_rdata = sel0 ? resp_rdata0 : resp_rdata1;
    wire [15:0] o_mem_addr   = sel0 ? mem_address0 : mem_address1;
    wire [15:0] o_mem_wdata  = sel0 ? mem_write_data0 : mem_write_data1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_rv(input logic v);
        if (sel0) rv0 = v; else rv1 = v;
    endtask

    task automatic set_rr(input logic v);
        if (sel0) rr0 = v; else rr1 = v;
    endtask

    // One complete request/response; poke offers an extra request while the
    // response is being held, which must be ignored.
    task automatic txn(input logic wr, input logic [15:0] addr, input logic [15:0] wd,
                       input int hold, input logic poke);
        int          idx;
        int          lat;
        int          exp_lat;
        int          pulses;
        logic [15:0] exp_rd;
        logic        exp_err;
        logic [15:0] exp_maddr;
        idx = sel0 ? 1 : 0;
        if (addr >= 16'd4) begin
            exp_err = 1'b1; exp_rd = '0; exp_lat = 1; exp_maddr = last_addr[idx];
        end else if (wr) begin
            exp_err = 1'b0; exp_rd = '0; exp_lat = 2; exp_maddr = addr;
        end else begin
            exp_err = 1'b0; exp_rd = model_mem[idx][addr[1:0]];
            exp_lat = sel0 ? 2 : 3; exp_maddr = addr;
        end

        @(negedge clk);
        check("req_ready_idle", {31'd0, o_req_ready}, 32'd1);
        req_write = wr; req_addr = addr; req_wdata = wd;
        set_rv(1'b1);
        @(posedge clk);
        lat = 0; pulses = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                set_rv(1'b0);
                if (!exp_err) check("issue_addr", {16'd0, o_mem_addr}, {16'd0, addr});
            end
            if (o_mem_load) begin
                pulses++;
                check("store_addr", {16'd0, o_mem_addr}, {16'd0, addr});
                check("store_data", {16'd0, o_mem_wdata}, {16'd0, wd});
            end
        end while (!o_resp_valid && lat < 20);

        check("latency", lat, exp_lat);
        check("resp_rdata", {16'd0, o_resp_rdata}, {16'd0, exp_rd});
        check("resp_err", {31'd0, o_resp_err}, {31'd0, exp_err});
        check("mem_load_pulses", pulses, (wr && !exp_err) ? 1 : 0);
        check("mem_addr_after", {16'd0, o_mem_addr}, {16'd0, exp_maddr});
        check("busy_resp", {31'd0, o_busy}, 32'd1);

        if (wr && !exp_err) model_mem[idx][addr[1:0]] = wd;
        last_addr[idx] = exp_maddr;

        for (int h = 0; h < hold; h++) begin
            if (poke && h == 0) begin
                req_write = 1'b1; req_addr = 16'd0; req_wdata = 16'hBEEF;
                set_rv(1'b1);
            end
            @(negedge clk);
            check("hold_valid", {31'd0, o_resp_valid}, 32'd1);
            check("hold_rdata", {16'd0, o_resp_rdata}, {16'd0, exp_rd});
            check("hold_err", {31'd0, o_resp_err}, {31'd0, exp_err});
            check("hold_ready", {31'd0, o_req_ready}, 32'd0);
            check("hold_mem_load", {31'd0, o_mem_load}, 32'd0);
        end
        set_rv(1'b0);
        set_rr(1'b1);
        @(negedge clk);
        set_rr(1'b0);
        check("done_valid", {31'd0, o_resp_valid}, 32'd0);
        check("done_busy", {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        logic [15:0] a;
        int          r;
        for (int u = 0; u < 2; u++) begin
            model_mem[u][0] = 16'd1;  model_mem[u][1] = 16'd22;
            model_mem[u][2] = 16'd5;  model_mem[u][3] = 16'd0;
            last_addr[u] = 16'd0;
        end

        // Reset state.
        #2 clr = 1'b0;
        @(negedge clk);
        check("rst_req_ready", {31'd0, req_ready1}, 32'd0);
        check("rst_resp_valid", {31'd0, resp_valid1}, 32'd0);
        check("rst_resp_err", {31'd0, resp_err1}, 32'd0);
        check("rst_rdata", {16'd0, resp_rdata1}, 32'd0);
        check("rst_mem_addr", {16'd0, mem_address1}, 32'd0);
        check("rst_mem_wdata", {16'd0, mem_write_data1}, 32'd0);
        check("rst_mem_load", {31'd0, mem_load1}, 32'd0);
        check("rst_busy", {31'd0, busy1}, 32'd0);
        clr = 1'b1;
        #1 check("rst_release_ready", {31'd0, req_ready1}, 32'd1);

        // Directed scenarios on the RD_WAIT=1 unit.
        txn(1'b0, 16'd1, 16'h0000, 0, 1'b0);      // load 22, latency 3
        txn(1'b1, 16'd3, 16'h00AB, 0, 1'b0);      // store pulse
        txn(1'b0, 16'd3, 16'h0000, 0, 1'b0);      // read back 0x00AB
        txn(1'b0, 16'd4, 16'h0000, 0, 1'b0);      // error, mem_address unchanged
        txn(1'b0, 16'h0101, 16'h0000, 1, 1'b0);   // no address truncation
        txn(1'b0, 16'd0, 16'h0000, 5, 1'b1);      // held response, ignored request
        txn(1'b0, 16'd0, 16'h0000, 0, 1'b0);      // ignored store left addr 0 intact

        // Reset during WAIT of a load to address 2.
        @(negedge clk);
        req_write = 1'b0; req_addr = 16'd2; rv1 = 1'b1;
        @(posedge clk);
        @(negedge clk); rv1 = 1'b0;
        @(negedge clk);
        check("wait_busy", {31'd0, busy1}, 32'd1);
        clr = 1'b0;
        #1;
        check("clr_busy", {31'd0, busy1}, 32'd0);
        check("clr_resp_valid", {31'd0, resp_valid1}, 32'd0);
        check("clr_mem_addr", {16'd0, mem_address1}, 32'd0);
        check("clr_req_ready", {31'd0, req_ready1}, 32'd0);
        last_addr[0] = 16'd0; last_addr[1] = 16'd0;
        @(negedge clk); clr = 1'b1;
        #1 check("clr_rise_ready", {31'd0, req_ready1}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("clr_no_resp", {31'd0, resp_valid1}, 32'd0);
        end

        // Reset during ISSUE of a store must kill the strobe at once.
        @(negedge clk);
        req_write = 1'b1; req_addr = 16'd1; req_wdata = 16'h1234; rv1 = 1'b1;
        @(posedge clk);
        @(negedge clk); rv1 = 1'b0;
        check("issue_strobe", {31'd0, mem_load1}, 32'd1);
        clr = 1'b0;
        #1 check("clr_strobe_drop", {31'd0, mem_load1}, 32'd0);
        last_addr[0] = 16'd0; last_addr[1] = 16'd0;
        @(negedge clk); clr = 1'b1;
        txn(1'b0, 16'd1, 16'h0000, 0, 1'b0);      // aborted store left 22

        // Randomized traffic on the RD_WAIT=1 unit.
        for (int i = 0; i < 24; i++) begin
            r = $urandom_range(0, 9);
            if (r < 8)       a = 16'(r % 4);
            else if (r == 8) a = 16'(4 + $urandom_range(0, 3));
            else             a = 16'h0100 | 16'($urandom_range(0, 3));
            txn(1'($urandom_range(0, 1)), a, 16'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        // RD_WAIT=0 unit.
        sel0 = 1'b1;
        txn(1'b0, 16'd2, 16'h0000, 0, 1'b0);      // returns 5, latency 2
        txn(1'b1, 16'd0, 16'h5A5A, 0, 1'b0);
        txn(1'b0, 16'd0, 16'h0000, 2, 1'b1);
        txn(1'b0, 16'hFFFF, 16'h0000, 0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            txn(1'($urandom_range(0, 1)), 16'($urandom_range(0, 5)), 16'($urandom),
                $urandom_range(0, 2), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
